// File: rtl/wb_cmd_master.sv
// Single-beat command/response to classic Wishbone read/write bridge for the 8-bit peripheral bus.
// Define WB_CMD_MASTER_TIMEOUT_EN to build the no-ack abort path (TIMEOUT cycles of unanswered strobe).
module wb_cmd_master #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic [7:0] cmd_adr,
   input  logic [7:0] cmd_dat,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_dat,
   output logic       rsp_err,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   input  logic       wb_ack_i,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t     state_r, state_s;
   logic       cmd_ready_s, rsp_valid_s, rsp_err_s;
   logic       cyc_s, stb_s, we_s, busy_s;
   logic [7:0] rsp_dat_s, adr_s, dat_s;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r, cnt_s;
`endif

   // Next-state and next-output decode for the command FSM.
   always_comb begin
      state_s     = state_r;
      cmd_ready_s = cmd_ready;
      rsp_valid_s = rsp_valid;
      rsp_err_s   = rsp_err;
      rsp_dat_s   = rsp_dat;
      adr_s       = wb_adr_o;
      dat_s       = wb_dat_o;
      cyc_s       = wb_cyc_o;
      stb_s       = wb_stb_o;
      we_s        = wb_we_o;
      busy_s      = busy;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      cnt_s       = cnt_r;
`endif

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               adr_s       = cmd_adr;
               dat_s       = cmd_dat;
               we_s        = cmd_we;
               cyc_s       = 1'b1;
               stb_s       = 1'b1;
               busy_s      = 1'b1;
               cmd_ready_s = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               cnt_s       = {CNT_W{1'b0}};
`endif
               state_s     = ST_BUS;
            end else begin
               cmd_ready_s = 1'b1;
            end
         end

         ST_BUS: begin
            // Ack is checked first so an ack on the expiry cycle still completes normally.
            if (wb_ack_i) begin
               cyc_s       = 1'b0;
               stb_s       = 1'b0;
               we_s        = 1'b0;
               rsp_dat_s   = wb_we_o ? 8'h00 : wb_dat_i;
               rsp_err_s   = 1'b0;
               rsp_valid_s = 1'b1;
               state_s     = ST_RESP;
            end else begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               if (cnt_r == CNT_LAST) begin
                  cyc_s       = 1'b0;
                  stb_s       = 1'b0;
                  we_s        = 1'b0;
                  rsp_dat_s   = 8'h00;
                  rsp_err_s   = 1'b1;
                  rsp_valid_s = 1'b1;
                  state_s     = ST_RESP;
               end else if (cnt_r != CNT_MAX) begin
                  cnt_s = cnt_r + CNT_ONE;
               end else begin
                  cnt_s = cnt_r;
               end
`else
               state_s = ST_BUS;
`endif
            end
         end

         ST_RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_s = 1'b0;
               busy_s      = 1'b0;
               cmd_ready_s = 1'b1;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end

         default: begin
            cyc_s       = 1'b0;
            stb_s       = 1'b0;
            we_s        = 1'b0;
            rsp_valid_s = 1'b0;
            busy_s      = 1'b0;
            cmd_ready_s = 1'b0;
            state_s     = ST_IDLE;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_dat   <= 8'h00;
         wb_adr_o  <= 8'h00;
         wb_dat_o  <= 8'h00;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_s;
         cmd_ready <= cmd_ready_s;
         rsp_valid <= rsp_valid_s;
         rsp_err   <= rsp_err_s;
         rsp_dat   <= rsp_dat_s;
         wb_adr_o  <= adr_s;
         wb_dat_o  <= dat_s;
         wb_cyc_o  <= cyc_s;
         wb_stb_o  <= stb_s;
         wb_we_o   <= we_s;
         busy      <= busy_s;
      end
   end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   // Unacknowledged-strobe cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_s;
      end
   end
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: vector table of bus commands plus hand sequences for corner cases.
module tb_wb_cmd_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_we = 1'b0;
   logic [7:0] cmd_adr = 8'h00;
   logic [7:0] cmd_dat = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_dat;
   logic       rsp_err;
   logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic       wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic       busy;

   logic       slv_ack;
   logic [7:0] slv_dat;
   logic [7:0] mem [0:31];
   logic       ack_inj = 1'b0;
   logic [7:0] inj_dat = 8'h00;

   int n_pass = 0;
   int n_total = 0;
   int stb_total = 0, ack_total = 0, hold_bad = 0;
   int stb_base, ack_base, bad_base;
   logic       exp_we;
   logic [7:0] exp_adr, exp_dat;

   assign wb_ack_i = slv_ack | ack_inj;
   assign wb_dat_i = ack_inj ? inj_dat : slv_dat;

   wb_cmd_master #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_ack_i(wb_ack_i), .busy(busy)
   );

   always #5 clk = ~clk;

   // Registered-ack slave covering 0x00-0x1F; anything above is unmapped and never acks.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i) ^ 8'h10;
         slv_ack <= 1'b0;
         slv_dat <= 8'h00;
      end else begin
         slv_ack <= 1'b0;
         if (wb_cyc_o && wb_stb_o && !slv_ack && wb_adr_o < 8'h20) begin
            slv_ack <= 1'b1;
            if (wb_we_o) mem[wb_adr_o[4:0]] <= wb_dat_o;
            else         slv_dat <= mem[wb_adr_o[4:0]];
         end
      end
   end

   // Bus monitor: strobe cycles, slave acks, and address/data/we stability while strobing.
   always @(posedge clk) begin
      if (wb_stb_o) begin
         stb_total++;
         if (wb_adr_o !== exp_adr || wb_we_o !== exp_we || (exp_we && wb_dat_o !== exp_dat))
            hold_bad++;
      end
      if (slv_ack) ack_total++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic send_cmd(input logic we, input logic [7:0] adr, input logic [7:0] dat);
      int n = 0;
      exp_we = we; exp_adr = adr; exp_dat = dat;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      stb_base = stb_total; ack_base = ack_total; bad_base = hold_bad;
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 100);
      check("rsp_wait", rsp_valid, 1);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_one_cycle", rsp_valid, 0);
      check("ready_after_rsp", cmd_ready, 1);
   endtask

   typedef struct {
      logic       we;
      logic [7:0] adr;
      logic [7:0] dat;
      logic [7:0] exp_rdat;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int lat;
      vecs[0] = '{1'b1, 8'h10, 8'h02, 8'h00};
      vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h02};
      vecs[2] = '{1'b0, 8'h11, 8'h00, 8'h01};
      vecs[3] = '{1'b1, 8'h1F, 8'hA5, 8'h00};
      vecs[4] = '{1'b0, 8'h1F, 8'h00, 8'hA5};
      vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h10};
      vecs[6] = '{1'b1, 8'h05, 8'h3C, 8'h00};
      vecs[7] = '{1'b0, 8'h05, 8'h00, 8'h3C};
      exp_we = 1'b0; exp_adr = 8'h00; exp_dat = 8'h00;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_dat", rsp_dat, 8'h00);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_wb_adr", wb_adr_o, 8'h00);
      check("rst_wb_dat", wb_dat_o, 8'h00);
      check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      #1 check("rel_cmd_ready_low", cmd_ready, 0);
      @(posedge clk);
      #1 check("rel_cmd_ready_high", cmd_ready, 1);

      for (int i = 0; i < 8; i++) begin
         send_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat);
         check($sformatf("v%0d_busy", i), busy, 1);
         wait_rsp(lat);
         check($sformatf("v%0d_latency", i), lat, 2);
         check($sformatf("v%0d_rsp_dat", i), rsp_dat, vecs[i].exp_rdat);
         check($sformatf("v%0d_rsp_err", i), rsp_err, 0);
         check($sformatf("v%0d_cyc_low", i), wb_cyc_o, 0);
         check($sformatf("v%0d_stb_cycles", i), stb_total - stb_base, 2);
         check($sformatf("v%0d_acks", i), ack_total - ack_base, 1);
         check($sformatf("v%0d_hold", i), hold_bad - bad_base, 0);
         take_rsp();
      end
      check("slave_reg_0x10", mem[16], 8'h02);

      // response held off for 5 cycles while a second command waits
      send_cmd(1'b0, 8'h11, 8'h00);
      wait_rsp(lat);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h10; cmd_dat = 8'h00;
      exp_we = 1'b0; exp_adr = 8'h10; exp_dat = 8'h00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d_rsp", k), {rsp_valid, rsp_dat, cmd_ready, wb_cyc_o}, {1'b1, 8'h01, 1'b0, 1'b0});
      end
      stb_base = stb_total; ack_base = ack_total; bad_base = hold_bad;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("hold_after_hs", {rsp_valid, cmd_ready, wb_cyc_o}, 3'b010);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("second_accepted", {wb_cyc_o, wb_stb_o, wb_adr_o}, {1'b1, 1'b1, 8'h10});
      wait_rsp(lat);
      check("second_rsp_dat", rsp_dat, 8'h02);
      check("second_acks", ack_total - ack_base, 1);
      take_rsp();

      // stray ack in IDLE
      inj_dat = 8'hEE; ack_inj = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack_inj = 1'b0;
      check("stray_idle", {cmd_ready, wb_cyc_o, rsp_valid, busy, rsp_dat}, {4'b1000, 8'h02});

      // stray ack in RESP
      send_cmd(1'b0, 8'h1F, 8'h00);
      wait_rsp(lat);
      ack_inj = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack_inj = 1'b0;
      check("stray_resp", {rsp_valid, wb_cyc_o, busy, rsp_dat}, {3'b101, 8'hA5});
      take_rsp();

      inj_dat = 8'h5A;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      send_cmd(1'b0, 8'h80, 8'h00);
      wait_rsp(lat);
      check("to_latency", lat, 4);
      check("to_stb_cycles", stb_total - stb_base, 4);
      check("to_rsp", {rsp_err, rsp_dat, wb_cyc_o, wb_stb_o}, {1'b1, 8'h00, 2'b00});
      take_rsp();
      send_cmd(1'b0, 8'h80, 8'h00);
      repeat (3) @(negedge clk);
      ack_inj = 1'b1;
      @(negedge clk);
      ack_inj = 1'b0;
      check("to_ack_wins", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 8'h5A});
      check("to_ack_stb_cycles", stb_total - stb_base, 4);
      take_rsp();
`else
      send_cmd(1'b0, 8'h80, 8'h00);
      repeat (20) @(negedge clk);
      check("noto_waiting", {wb_cyc_o, wb_stb_o, rsp_valid, rsp_err}, 4'b1100);
      ack_inj = 1'b1;
      @(negedge clk);
      ack_inj = 1'b0;
      check("noto_late_ack", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 8'h5A});
      check("noto_stb_cycles", stb_total - stb_base, 21);
      take_rsp();
`endif

      // asynchronous reset while in BUS
      send_cmd(1'b0, 8'h80, 8'h00);
      @(negedge clk);
      check("bus_before_rst", {wb_cyc_o, wb_stb_o}, 2'b11);
      #2 rst = 1'b1;
      #1 check("rst_async_drop", {wb_cyc_o, wb_stb_o, rsp_valid, busy, cmd_ready}, 5'b00000);
      repeat (2) @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
      rst = 1'b0;
      #1 check("rst2_ready_low", cmd_ready, 0);
      @(posedge clk);
      #1 check("rst2_ready_high", cmd_ready, 1);
      send_cmd(1'b0, 8'h11, 8'h00);
      wait_rsp(lat);
      check("post_rst_read", {rsp_err, rsp_dat}, {1'b0, 8'h01});
      check("post_rst_latency", lat, 2);
      take_rsp();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "bench watchdog expired");
   end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone initiator that turns a single-beat command/response handshake into classic Wishbone read and write cycles on the 8-bit peripheral bus. It sits between a host-side command source, such as a UART or SPI command decoder, and the slave decode fabric. Video control sits at slave 1, 0x10–0x1F. It issues exactly one bus cycle per command, returns read data or write completion, and optionally aborts cycles that are never acknowledged.

## Interface
- TIMEOUT, 64, number of cycles `wb_stb_o` stays high without `wb_ack_i` before the cycle is aborted; legal range 1–65535. Used only with WB_CMD_MASTER_TIMEOUT_EN.

- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  8  target bus address
- cmd_dat  in  8  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_dat  out  8  read data; 0x00 for writes and errors
- rsp_err  out  1  cycle aborted by timeout
- wb_adr_o  out  8  bus address
- wb_dat_o  out  8  bus write data
- wb_dat_i  in  8  bus read data
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_we_o  out  1  bus write enable
- wb_ack_i  in  1  bus acknowledge
- busy  out  1  high in BUS or RESP state

## Operation
- All outputs are registered. Reset values:
  - `cmd_ready`=0 and `rsp_valid`=0.
  - `rsp_dat`, `wb_adr_o` and `wb_dat_o` = 0x00.
  - `rsp_err`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o` and `busy` = 0.
  - State = IDLE.
- `cmd_ready` rises on the first clk edge after rst deasserts.
- IDLE: `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch `cmd_adr`, `cmd_dat` and `cmd_we` into `wb_adr_o`, `wb_dat_o` and `wb_we_o`.
  - Assert `wb_cyc_o`, `wb_stb_o` and `busy`; deassert `cmd_ready`; clear the timeout counter; go to BUS.
- BUS: `wb_cyc_o` and `wb_stb_o` stay high. Address, data and we are held stable.
  - On `wb_ack_i`=1, drop `wb_cyc_o`, `wb_stb_o` and `wb_we_o`.
  - For a read, `rsp_dat` takes `wb_dat_i`. For a write, `rsp_dat` is 0x00.
  - Set `rsp_err`=0 and `rsp_valid`=1, then go to RESP.
  - Otherwise the timeout counter increments.
- Timeout: if `wb_stb_o` has been high for TIMEOUT cycles with no ack, drop cyc and stb.
  - Set `rsp_dat`=0x00, `rsp_err`=1 and `rsp_valid`=1, then go to RESP.
  - If ack arrives on the expiry cycle, ack wins and the response is a normal one.
- RESP: `rsp_valid`, `rsp_dat` and `rsp_err` are held until `rsp_valid & rsp_ready`.
  - Then clear `rsp_valid` and `busy`, set `cmd_ready`=1, and return to IDLE.
  - No command is accepted while a response is pending.
- `wb_ack_i` is ignored outside BUS. A stray ack has no effect.
- Exactly one strobe is issued per command. Strobe drops on the edge that samples ack, so a slave that gates its ack with `!wb_ack_o` produces a single ack.
- The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Timing
- Command accepted at edge N: cyc, stb, adr, dat and we are valid from edge N through the ack edge.
- With a registered-ack slave, ack is sampled at edge N+2. Cyc and stb are low after N+2, and `rsp_valid` is high after N+2.
- Best-case command-to-response latency is 2 cycles; the next command can be accepted 1 cycle after the response handshake.
- Timeout: stb is high for exactly TIMEOUT cycles, then `rsp_valid`/`rsp_err` assert on the same edge that cyc and stb drop.
- Reset mid-operation, asynchronous: cyc and stb drop immediately, the pending command and response are discarded, and all outputs take their reset values.
- `rsp_valid` with `rsp_ready` held high: the response lasts 1 cycle.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN defined: timeout counter and abort path are present as described; `rsp_err` reports aborts.
- Not defined: no counter is built and TIMEOUT is unused. BUS waits for ack indefinitely, and `rsp_err` is constant 0.

## Test plan
- Write to 0x10 with data 0x02 against a registered-ack slave:
  - one cyc/stb pulse of 2 cycles, with we=1, adr=0x10 and dat=0x02 held;
  - `rsp_valid` with `rsp_dat`=0x00 and `rsp_err`=0;
  - the slave register reads 0x02.
- Read 0x11 from a slave returning 0x01 → `rsp_dat`=0x01 and `rsp_err`=0; the ack is counted exactly once.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid` and data stay stable, `cmd_ready`=0, and a second `cmd_valid` is not accepted until the handshake.
- With the macro defined and TIMEOUT=4, read an unmapped address that is never acked:
  - stb is high for exactly 4 cycles;
  - response is `rsp_err`=1 with `rsp_dat`=0x00.
  - Repeat with ack on the 4th cycle → `rsp_err`=0.
- Assert rst while in BUS → cyc and stb go to 0 before the next edge, and no `rsp_valid` is produced. After release, `cmd_ready`=1 one edge later and a new read completes normally.
- Inject a stray `wb_ack_i` in IDLE and RESP → no state change; `rsp_dat` is unchanged.
